// File: rtl/inst_mem_multi.sv
// Multi-port instruction memory with reset-time image load and a
// streaming valid/ready reload port driven by a small load FSM.
module inst_mem_multi #(
    parameter int W       = 32,
    parameter int L       = 6,
    parameter int R       = 1,
    parameter int REG_OUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [(2**L)*W-1:0]   inst_mem_in_wire,
    input  logic [R*30-1:0]       pc,
    input  logic [R-1:0]          rd_en,
    output logic [R*W-1:0]        opcode,
    output logic [R-1:0]          oob,
    input  logic                  load_start,
    input  logic [L-1:0]          load_base,
    input  logic [L:0]            load_len,
    input  logic                  load_valid,
    input  logic [W-1:0]          load_data,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic                  load_done
);

    localparam int N = 2 ** L;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [L-1:0]   ptr_q, ptr_d;
    logic [L:0]     cnt_q, cnt_d;
    logic [W-1:0]   mem_q [N];
    logic [W-1:0]   mem_d [N];
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    ptr_d   = load_base;
                    cnt_d   = load_len;
                    state_d = (load_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    mem_d[ptr_q] = load_data;
                    ptr_d        = ptr_q + 1'b1;
                    cnt_d        = cnt_q - 1'b1;
                    if (cnt_q == (L+1)'(1)) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_LOAD);
        busy_d  = (state_d == S_LOAD);
        done_d  = (state_d == S_DONE);
    end

    // Reset re-images the whole array, which also aborts any load in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int g = 0; g < N; g++) begin
                mem_q[g] <= inst_mem_in_wire[g*W +: W];
            end
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            for (int g = 0; g < N; g++) begin
                mem_q[g] <= mem_d[g];
            end
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign load_ready = ready_q;
    assign load_busy  = busy_q;
    assign load_done  = done_q;

    logic [W-1:0] rd_word [R];
    logic [R-1:0] rd_oob;

    for (genvar c = 0; c < R; c++) begin : g_dec
        logic [29:0] pc_c;
        assign pc_c      = pc[c*30 +: 30];
        assign rd_oob[c] = |pc_c[29:L];
        assign rd_word[c] = rd_oob[c] ? '0 : mem_q[pc_c[L-1:0]];
    end

    if (REG_OUT != 0) begin : g_reg
        logic [R*W-1:0] op_q, op_d;
        logic [R-1:0]   oob_q, oob_d;

        always_comb begin
            op_d  = op_q;
            oob_d = oob_q;
            for (int c = 0; c < R; c++) begin
                if (rd_en[c]) begin
                    op_d[c*W +: W] = rd_word[c];
                    oob_d[c]       = rd_oob[c];
                end
            end
        end

        // Captures pre-edge memory, so a same-cycle write reads old data.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                op_q  <= '0;
                oob_q <= '0;
            end else begin
                op_q  <= op_d;
                oob_q <= oob_d;
            end
        end

        assign opcode = op_q;
        assign oob    = oob_q;
    end else begin : g_comb
        logic unused_rd_en;
        assign unused_rd_en = ^rd_en;
        for (genvar c = 0; c < R; c++) begin : g_out
            assign opcode[c*W +: W] = rd_word[c];
        end
        assign oob = rd_oob;
    end

endmodule
